// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with an auto-scan sequencer.
// Each scan position is held for dwell+1 cycles; wrap pulses when the index rolls over.
module decoder_scan #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic                  load,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(2**SEL_W)-1:0] y,
  output logic [SEL_W-1:0]      sel_out,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;

  typedef enum logic [1:0] {
    M_DIRECT    = 2'b00,
    M_SCAN_UP   = 2'b01,
    M_SCAN_DOWN = 2'b10,
    M_HOLD      = 2'b11
  } mode_e;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [OUT_W-1:0] r;
    r    = '0;
    r[s] = 1'b1;
    return r;
  endfunction

  logic [DWELL_W-1:0] cnt_p1;
  logic [SEL_W-1:0]   idx_p0;
  logic [DWELL_W-1:0] cnt_p0;
  logic               wrap_p0;
  mode_e              mode_q;

  assign mode_q = mode_e'(mode);

  // Stage 0: next scan index / dwell count; sel_out doubles as the index register
  always_comb begin
    idx_p0  = sel_out;
    cnt_p0  = cnt_p1 + DWELL_W'(1);
    wrap_p0 = 1'b0;
    if (load) begin
      idx_p0 = sel_in;
      cnt_p0 = '0;
    end else if (cnt_p1 == dwell) begin
      cnt_p0 = '0;
      if (mode_q == M_SCAN_DOWN) begin
        idx_p0  = sel_out - SEL_W'(1);
        wrap_p0 = (sel_out == '0);
      end else begin
        idx_p0  = sel_out + SEL_W'(1);
        wrap_p0 = (sel_out == SEL_W'(OUT_W - 1));
      end
    end
  end

  // Stage 1: registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      sel_out <= '0;
      wrap    <= 1'b0;
      cnt_p1  <= '0;
    end else if (!en) begin
      y    <= '0;
      wrap <= 1'b0;
    end else begin
      case (mode_q)
        M_DIRECT: begin
          sel_out <= sel_in;
          y       <= onehot(sel_in);
          cnt_p1  <= '0;
          wrap    <= 1'b0;
        end
        M_SCAN_UP, M_SCAN_DOWN: begin
          sel_out <= idx_p0;
          y       <= onehot(idx_p0);
          cnt_p1  <= cnt_p0;
          wrap    <= wrap_p0;
        end
        default: begin
          // Re-derive y so an enable returning during HOLD restores the strobe
          y    <= onehot(sel_out);
          wrap <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Directed testbench for decoder_scan (SEL_W=2 main instance, SEL_W=3 secondary).
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [1:0] mode;
  logic [1:0] sel_in;
  logic [3:0] dwell;
  logic [3:0] y;
  logic [1:0] sel_out;
  logic       wrap;
  logic [2:0] sel_in3;
  logic [7:0] y3;
  logic [2:0] sel_out3;
  logic       wrap3;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(2), .DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in),
    .load(load), .dwell(dwell), .y(y), .sel_out(sel_out), .wrap(wrap)
  );

  decoder_scan #(.SEL_W(3), .DWELL_W(4)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in3),
    .load(load), .dwell(dwell), .y(y3), .sel_out(sel_out3), .wrap(wrap3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 2'b00; sel_in = 2'd3; sel_in3 = 3'd0;
    load = 1'b0; dwell = 4'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      nvec++;
      if (y !== 4'b0000 || sel_out !== 2'd0 || wrap !== 1'b0) begin
        nfail++;
        $display("FAIL reset[%0d]: y=%b sel_out=%0d wrap=%b, want y=0000 sel_out=0 wrap=0", i, y, sel_out, wrap);
      end
    end
  endtask

  task automatic test_direct();
    logic [3:0] exp;
    rst = 1'b0;
    mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      sel_in = 2'(i);
      tick();
      exp = 4'b0001 << i;
      nvec++;
      if (y !== exp || sel_out !== 2'(i) || wrap !== 1'b0) begin
        nfail++;
        $display("FAIL direct[%0d]: y=%b sel_out=%0d wrap=%b, want y=%b sel_out=%0d wrap=0", i, y, sel_out, wrap, exp, i);
      end
    end
  endtask

  task automatic test_scan_up();
    logic [3:0] ey [9];
    ey = '{4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0001};
    mode = 2'b01; dwell = 4'd2; sel_in = 2'd2; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      nvec++;
      if (y !== ey[i] || wrap !== (i == 6)) begin
        nfail++;
        $display("FAIL scan_up[%0d]: y=%b wrap=%b, want y=%b wrap=%b", i, y, wrap, ey[i], (i == 6));
      end
    end
  endtask

  task automatic test_scan_down();
    logic [3:0] ey [4];
    ey = '{4'b0010, 4'b0001, 4'b1000, 4'b0100};
    mode = 2'b10; dwell = 4'd0; sel_in = 2'd1; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      nvec++;
      if (y !== ey[i] || wrap !== (i == 2)) begin
        nfail++;
        $display("FAIL scan_down[%0d]: y=%b wrap=%b, want y=%b wrap=%b", i, y, wrap, ey[i], (i == 2));
      end
    end
  endtask

  task automatic test_load_collision();
    logic [3:0] ey [4];
    ey = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
    mode = 2'b01; dwell = 4'd2; sel_in = 2'd1; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    // Counter now equals dwell: a step to 0100 is due on this edge, load must win
    sel_in = 2'd0; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      nvec++;
      if (y !== ey[i] || wrap !== 1'b0) begin
        nfail++;
        $display("FAIL load_collision[%0d]: y=%b wrap=%b, want y=%b wrap=0", i, y, wrap, ey[i]);
      end
    end
  endtask

  task automatic test_enable_hold();
    logic [3:0] ey [3];
    ey = '{4'b0100, 4'b0100, 4'b1000};
    mode = 2'b01; dwell = 4'd3; sel_in = 2'd2; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      nvec++;
      if (y !== 4'b0000 || sel_out !== 2'd2 || wrap !== 1'b0) begin
        nfail++;
        $display("FAIL disabled[%0d]: y=%b sel_out=%0d wrap=%b, want y=0000 sel_out=2 wrap=0", i, y, sel_out, wrap);
      end
    end
    // Held counter 1 resumes at 2, so dwell 3 leaves two more cycles here
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++;
      if (y !== ey[i] || sel_out !== (i == 2 ? 2'd3 : 2'd2)) begin
        nfail++;
        $display("FAIL resume[%0d]: y=%b sel_out=%0d, want y=%b", i, y, sel_out, ey[i]);
      end
    end
    mode = 2'b11;
    for (int i = 0; i < 8; i++) begin
      tick();
      nvec++;
      if (y !== 4'b1000 || sel_out !== 2'd3 || wrap !== 1'b0) begin
        nfail++;
        $display("FAIL hold[%0d]: y=%b sel_out=%0d wrap=%b, want y=1000 sel_out=3 wrap=0", i, y, sel_out, wrap);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    mode = 2'b01; dwell = 4'd0; sel_in = 2'd2; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    rst = 1'b1; load = 1'b1; sel_in = 2'd3;
    tick();
    nvec++;
    if (y !== 4'b0000 || sel_out !== 2'd0 || wrap !== 1'b0) begin
      nfail++;
      $display("FAIL reset_mid_scan: y=%b sel_out=%0d wrap=%b, want y=0000 sel_out=0 wrap=0", y, sel_out, wrap);
    end
    nvec++;
    if (y3 !== 8'h00 || sel_out3 !== 3'd0 || wrap3 !== 1'b0) begin
      nfail++;
      $display("FAIL reset_mid_scan_w3: y=%b sel_out=%0d wrap=%b, want all zero", y3, sel_out3, wrap3);
    end
    rst = 1'b0; load = 1'b0;
  endtask

  task automatic test_sel3_walk();
    logic [7:0] exp;
    int wraps;
    wraps = 0;
    mode = 2'b01; dwell = 4'd0; sel_in3 = 3'd0; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      exp = 8'b0000_0001 << (i % 8);
      if (wrap3 === 1'b1) wraps++;
      nvec++;
      if (y3 !== exp || sel_out3 !== 3'(i % 8) || wrap3 !== (i == 8)) begin
        nfail++;
        $display("FAIL sel3_walk[%0d]: y=%b sel_out=%0d wrap=%b, want y=%b sel_out=%0d wrap=%b",
                 i, y3, sel_out3, wrap3, exp, i % 8, (i == 8));
      end
    end
    nvec++;
    if (wraps !== 1) begin
      nfail++;
      $display("FAIL sel3_wrap_count: got %0d wrap pulses, want 1", wraps);
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_up();
    test_scan_down();
    test_load_collision();
    test_enable_hold();
    test_reset_mid_scan();
    test_sel3_walk();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
